// File: rtl/pc_update_sequencer_if.sv
// Request/response bundle between the main control unit and the PC update sequencer.
// The control unit is the master; the sequencer is the slave.
interface pc_update_sequencer_if;
    logic        req;
    logic [2:0]  kind;
    logic        branch_taken;
    logic        exc_invalid;
    logic        exc_ovf;
    logic        exc_div0;
    logic [1:0]  pc_source;
    logic        pc_write;
    logic        epc_write;
    logic        mem_read;
    logic [31:0] exc_addr;
    logic [1:0]  exc_cause;
    logic        busy;
    logic        done;

    modport master (
        output req, kind, branch_taken, exc_invalid, exc_ovf, exc_div0,
        input  pc_source, pc_write, epc_write, mem_read, exc_addr, exc_cause, busy, done
    );

    modport slave (
        input  req, kind, branch_taken, exc_invalid, exc_ovf, exc_div0,
        output pc_source, pc_write, epc_write, mem_read, exc_addr, exc_cause, busy, done
    );
endinterface

// File: rtl/pc_update_sequencer.sv
// Multicycle controller sequencing every PC update, including the EPC save and
// handler-vector fetch for exceptions. All outputs come straight from flops.
module pc_update_sequencer #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_update_sequencer_if.slave bus
);
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ADDR_W = 32;

    localparam logic [1:0] SRC_JUMP = 2'b00;
    localparam logic [1:0] SRC_EPC  = 2'b01;
    localparam logic [1:0] SRC_MEM  = 2'b10;
    localparam logic [1:0] SRC_ALU  = 2'b11;

    localparam logic [1:0] CAUSE_INV  = 2'b01;
    localparam logic [1:0] CAUSE_OVF  = 2'b10;
    localparam logic [1:0] CAUSE_DIV0 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_EXC_EPC,
        ST_EXC_READ,
        ST_EXC_LOAD
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        pc_source_q;
    logic              pc_write_q;
    logic              epc_write_q;
    logic              mem_read_q;
    logic [ADDR_W-1:0] exc_addr_q;
    logic [1:0]        exc_cause_q;
    logic              busy_q;
    logic              done_q;

    // Request decode: exception cause by priority, and the PC update for plain requests.
    logic       exc_any_c;
    logic [1:0] cause_c;
    logic [1:0] src_c;
    logic       wr_c;
    logic [ADDR_W-1:0] vector_c;

    always_comb begin
        exc_any_c = bus.exc_invalid | bus.exc_ovf | bus.exc_div0;
        cause_c   = 2'b00;
        if (bus.exc_invalid)   cause_c = CAUSE_INV;
        else if (bus.exc_ovf)  cause_c = CAUSE_OVF;
        else if (bus.exc_div0) cause_c = CAUSE_DIV0;

        src_c = SRC_ALU;
        wr_c  = 1'b1;
        case (bus.kind)
            3'b001:  src_c = SRC_JUMP;
            3'b010:  wr_c  = bus.branch_taken;
            3'b011:  src_c = SRC_EPC;
            default: ;
        endcase

        // Vectors 253..255 map onto causes 01..11.
        vector_c = ADDR_W'(252) + ADDR_W'(exc_cause_q);
    end

    // Outputs are loaded on each transition so they are valid during the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pc_source_q <= SRC_JUMP;
            pc_write_q  <= 1'b0;
            epc_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            exc_addr_q  <= '0;
            exc_cause_q <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req && exc_any_c) begin
                        state_q     <= ST_EXC_EPC;
                        exc_cause_q <= cause_c;
                        epc_write_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (bus.req) begin
                        state_q     <= ST_UPDATE;
                        pc_source_q <= src_c;
                        pc_write_q  <= wr_c;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    state_q    <= ST_IDLE;
                    pc_write_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                end
                ST_EXC_EPC: begin
                    state_q     <= ST_EXC_READ;
                    cnt_q       <= CNT_W'(MEM_WAIT - 1);
                    epc_write_q <= 1'b0;
                    mem_read_q  <= 1'b1;
                    exc_addr_q  <= vector_c;
                end
                ST_EXC_READ: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_EXC_LOAD;
                        mem_read_q  <= 1'b0;
                        pc_source_q <= SRC_MEM;
                        pc_write_q  <= 1'b1;
                        done_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_EXC_LOAD: begin
                    state_q    <= ST_IDLE;
                    pc_write_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    exc_addr_q <= '0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    pc_write_q  <= 1'b0;
                    epc_write_q <= 1'b0;
                    mem_read_q  <= 1'b0;
                    exc_addr_q  <= '0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_source = pc_source_q;
    assign bus.pc_write  = pc_write_q;
    assign bus.epc_write = epc_write_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.exc_addr  = exc_addr_q;
    assign bus.exc_cause = exc_cause_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
